// File: rtl/mips4_fetch_exec_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer feeding a 4-bit ALU.
// Owns the program memory, the 4-entry register file and the 16-entry data memory.
module mips4_fetch_exec_ctrl #(
    parameter int IMEM_DEPTH = 16,
    parameter int NUM_REGS   = 4,
    parameter int DATA_W     = 4,
    parameter int PC_W       = $clog2(IMEM_DEPTH),
    parameter int DMEM_DEPTH = 2 ** DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [11:0]       prog_data,
    input  logic              run,
    input  logic [PC_W-1:0]   last_pc,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_operandA,
    output logic [DATA_W-1:0] alu_operandB,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_mem_read,
    input  logic              alu_mem_write,
    output logic [DATA_W-1:0] alu_memory_in,
    input  logic [DATA_W-1:0] alu_memory_out,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [11:0]         ir_q, ir_d;
    logic [3:0]          opc_q, opc_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                mwr_q, mwr_d;
    logic [DATA_W-1:0]   mout_q, mout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [11:0]         imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0]   rf_q   [NUM_REGS];
    logic [DATA_W-1:0]   dmem_q [DMEM_DEPTH];

    logic                imem_we_s;
    logic                rf_we_s;
    logic                dm_we_s;

    // Next-state, datapath register updates and memory write strobes.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        opc_d     = opc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        mwr_d     = mwr_q;
        mout_d    = mout_q;
        done_d    = 1'b0;
        imem_we_s = 1'b0;
        rf_we_s   = 1'b0;
        dm_we_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                imem_we_s = prog_we;
                if (run) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                ir_d    = imem_q[pc_q];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                opc_d   = ir_q[11:8];
                opa_d   = rf_q[ir_q[5:4]];
                opb_d   = ir_q[3:0];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = alu_result;
                mwr_d   = alu_mem_write;
                mout_d  = alu_memory_out;
                state_d = S_WB;
            end
            S_WB: begin
                // Stores go to data memory only; every other op (loads included) commits res_q.
                if (mwr_q) begin
                    dm_we_s = 1'b1;
                end else begin
                    rf_we_s = 1'b1;
                end
                if (pc_q == last_pc) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer and ALU-facing registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            opc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            mwr_q   <= 1'b0;
            mout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opc_q   <= opc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            mwr_q   <= mwr_d;
            mout_q  <= mout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Program memory survives reset so a loaded program can be rerun.
    always_ff @(posedge clk) begin
        if (imem_we_s) begin
            imem_q[prog_addr] <= prog_data;
        end
    end

    // Register file and data memory, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
            for (int j = 0; j < DMEM_DEPTH; j++) begin
                dmem_q[j] <= '0;
            end
        end else begin
            if (rf_we_s) begin
                rf_q[ir_q[7:6]] <= res_q;
            end
            if (dm_we_s) begin
                dmem_q[opb_q] <= mout_q;
            end
        end
    end

    assign alu_opcode    = opc_q;
    assign alu_operandA  = opa_q;
    assign alu_operandB  = opb_q;
    assign alu_memory_in = alu_mem_read ? dmem_q[opb_q] : '0;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pc            = pc_q;
    assign dbg_data      = rf_q[dbg_sel];

endmodule

// File: tb/tb_mips4_fetch_exec_ctrl.sv
// Bench for mips4_fetch_exec_ctrl with a behavioural ALU stub and a register-file scoreboard.
module tb_mips4_fetch_exec_ctrl;

    logic        clk, reset, prog_we, run;
    logic [3:0]  prog_addr, last_pc;
    logic [11:0] prog_data;
    logic [3:0]  alu_opcode, alu_operandA, alu_operandB, alu_result;
    logic        alu_mem_read, alu_mem_write;
    logic [3:0]  alu_memory_in, alu_memory_out;
    logic        busy, done;
    logic [3:0]  pc;
    logic [1:0]  dbg_sel;
    logic [3:0]  dbg_data;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] val;
    } exp_t;
    exp_t       sb_q[$];
    logic [3:0] rmodel [4];

    typedef struct {
        logic [11:0] instr;
        logic [1:0]  dst;
        logic [3:0]  exp_val;
    } vec_t;
    vec_t vecs [6];

    mips4_fetch_exec_ctrl dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .last_pc(last_pc),
        .alu_opcode(alu_opcode), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_result(alu_result), .alu_mem_read(alu_mem_read), .alu_mem_write(alu_mem_write),
        .alu_memory_in(alu_memory_in), .alu_memory_out(alu_memory_out),
        .busy(busy), .done(done), .pc(pc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result     = 4'd0;
        alu_mem_read   = 1'b0;
        alu_mem_write  = 1'b0;
        alu_memory_out = 4'd0;
        case (alu_opcode)
            4'b0000: alu_result = alu_operandA + alu_operandB;
            4'b1010: begin
                alu_mem_read = 1'b1;
                alu_result   = alu_memory_in;
            end
            4'b1011: begin
                alu_mem_write  = 1'b1;
                alu_memory_out = alu_operandA;
            end
            default: alu_result = 4'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] addr, input logic [11:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic expect_reg(input logic [1:0] sel, input logic [3:0] val);
        exp_t e;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
        rmodel[sel] = val;
    endtask

    task automatic drain_sb(input string name);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            dbg_sel = e.sel;
            #1;
            check({name, "_reg"}, dbg_data, e.val);
        end
    endtask

    task automatic sweep_regs(input string name);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = r[1:0];
            #1;
            check({name, "_dbg"}, dbg_data, rmodel[r]);
        end
    endtask

    // Starts the program, waits (bounded) for done, checks its cycle and single-cycle width.
    task automatic run_prog(input logic [3:0] lp, input int exp_cyc, input string name);
        int cyc;
        bit seen;
        last_pc = lp;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check({name, "_busy"}, busy, 1);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
        end
        check({name, "_done_cyc"}, cyc, exp_cyc);
        check({name, "_idle"}, busy, 0);
        @(negedge clk);
        check({name, "_done_width"}, done, 0);
    endtask

    initial begin
        int cyc, ndone, first;
        bit switched;
        clk = 1'b0; reset = 1'b1; prog_we = 1'b0; run = 1'b0;
        prog_addr = 4'd0; prog_data = 12'd0; last_pc = 4'd0; dbg_sel = 2'd0;
        for (int r = 0; r < 4; r++) rmodel[r] = 4'd0;

        vecs[0] = '{12'b0000_00_00_0111, 2'd0, 4'd7};
        vecs[1] = '{12'b0000_01_00_1001, 2'd1, 4'd0};
        vecs[2] = '{12'b0000_10_00_0011, 2'd2, 4'd10};
        vecs[3] = '{12'b1011_00_10_0101, 2'd0, 4'd7};
        vecs[4] = '{12'b1010_11_00_0101, 2'd3, 4'd10};
        vecs[5] = '{12'b0000_00_11_1111, 2'd0, 4'd9};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc", pc, 0);
        check("rst_opc", alu_opcode, 0);
        check("rst_opa", alu_operandA, 0);
        check("rst_opb", alu_operandB, 0);
        sweep_regs("rst");
        reset = 1'b0;

        // Reset while the store is in EXEC: nothing may commit.
        load(4'd0, 12'b0000_10_00_1001);
        load(4'd1, 12'b1011_00_10_0011);
        last_pc = 4'd1;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_opc_exec", alu_opcode, 4'b1011);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_pc", pc, 0);
        check("midrst_done", done, 0);
        check("midrst_opb", alu_operandB, 0);
        sweep_regs("midrst");
        @(negedge clk);
        check("midrst_done_hold", done, 0);
        reset = 1'b0;
        load(4'd0, 12'b1010_11_00_0011);
        expect_reg(2'd3, 4'd0);
        run_prog(4'd0, 4, "midrst_lw");
        drain_sb("midrst_lw");

        // Single add.
        load(4'd0, 12'b0000_01_00_0101);
        expect_reg(2'd1, 4'd5);
        run_prog(4'd0, 4, "single_add");
        check("single_add_pc", pc, 0);
        drain_sb("single_add");

        // Add, store, load.
        load(4'd0, 12'b0000_10_00_1001);
        load(4'd1, 12'b1011_00_10_0011);
        load(4'd2, 12'b1010_11_00_0011);
        expect_reg(2'd2, 4'd9);
        expect_reg(2'd3, 4'd9);
        run_prog(4'd2, 12, "st_ld");
        check("st_ld_pc", pc, 2);
        drain_sb("st_ld");

        for (int v = 0; v < 6; v++) begin
            load(4'd0, vecs[v].instr);
            expect_reg(vecs[v].dst, vecs[v].exp_val);
            run_prog(4'd0, 4, $sformatf("vec%0d", v));
            drain_sb($sformatf("vec%0d", v));
        end
        sweep_regs("vec_sweep");

        // Sixteen increments of R0 fill the whole program memory.
        load(4'd0, 12'b0000_00_01_0001);
        for (int a = 1; a < 16; a++) load(a[3:0], 12'b0000_00_00_0001);
        expect_reg(2'd0, 4'd0);
        run_prog(4'd15, 64, "full16");
        check("full16_pc", pc, 15);
        drain_sb("full16");

        // last_pc moved to 0 once pc reaches 15, forcing a 15->0 wrap.
        last_pc = 4'd15;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        cyc = 0; ndone = 0; first = 0; switched = 0;
        while (cyc < 90) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (first == 0) first = cyc;
            end
            if (!switched && pc == 4'd15) begin
                last_pc  = 4'd0;
                switched = 1;
            end
        end
        check("wrap_done_cyc", first, 68);
        check("wrap_done_count", ndone, 1);
        check("wrap_pc", pc, 0);
        expect_reg(2'd0, 4'd1);
        drain_sb("wrap");

        // prog_we and run while busy must be ignored.
        load(4'd0, 12'b0000_01_00_0011);
        load(4'd1, 12'b0000_10_01_0001);
        last_pc = 4'd1;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        ndone = 0; first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = k;
            end
            if (k == 2) begin
                prog_we   = 1'b1;
                prog_addr = 4'd0;
                prog_data = 12'b0000_01_00_1111;
                run       = 1'b1;
            end else begin
                prog_we = 1'b0;
                run     = 1'b0;
            end
        end
        check("busy_ign_done_cyc", first, 8);
        check("busy_ign_done_count", ndone, 1);
        expect_reg(2'd1, 4'd4);
        expect_reg(2'd2, 4'd5);
        drain_sb("busy_ign");
        expect_reg(2'd1, 4'd4);
        expect_reg(2'd2, 4'd5);
        run_prog(4'd1, 8, "busy_ign_rerun");
        drain_sb("busy_ign_rerun");
        sweep_regs("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
